aes_256_out_buffer: RTL



---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_sync_fifo.sv | 63 ++++++
 rtl/aes_256_out_buffer.sv | 81 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES-256 datapath blocks.
// Holds block/key widths, core pipeline latency and the occupancy width function.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES256_KEY_W    = 256;
    localparam int AES256_PIPE_LAT = 15;

    // Bits needed to hold any value 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Single-clock FIFO with registered storage and a muxed (fall-through) head.
// Ports: wr_en/wr_data write side, rd_en/rd_data read side, count/full/empty status.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_256_out_buffer.sv
// Output buffer for the fixed-latency, non-stalling AES-256 core.
// Ports: clk/rst; issue_valid/issue_ready gate core issues; core_out is the
// core result; ct_valid/ct_ready/ct_data present ciphertext; occupancy counts
// blocks in flight plus stored.
module aes_256_out_buffer
    import aes_pkg::*;
#(
    parameter int LATENCY = AES256_PIPE_LAT,
    parameter int DEPTH   = 16,
    parameter int WIDTH   = AES_BLOCK_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [WIDTH-1:0]         core_out,
    output logic                     ct_valid,
    input  logic                     ct_ready,
    output logic [WIDTH-1:0]         ct_data,
    output logic [occ_w(DEPTH)-1:0]  occupancy
);

    localparam int OW = occ_w(DEPTH);

    logic [LATENCY-1:0]           vld_sr;
    logic                         accept;
    logic                         capture;
    logic                         pop;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    logic                         unused_fifo;

    assign accept   = issue_valid & issue_ready;
    assign capture  = vld_sr[LATENCY-1];
    assign ct_valid = ~fifo_empty;
    assign pop      = ct_valid & ct_ready;

    // Registered counter only: a pop returns its credit one cycle later.
    assign issue_ready = (occupancy < OW'(DEPTH));

    // Bit k marks that core stage k carries a real block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | LATENCY'(accept);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    aes_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (core_out),
        .rd_en   (ct_ready),
        .rd_data (ct_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Credits guarantee the FIFO never overflows, so its status is not needed.
    assign unused_fifo = ^{fifo_count, fifo_full};

endmodule
